sample_widen: RTL and testbench

Input-side conditioning stage for the LMS datapath, and the converse of the output saturation stage. It accepts 16-bit signed samples over a valid/ready handshake and widens each one to the 32-bit accumulator format by sign extension and a fixed left shift. Results are buffered in a small FIFO and tagged with a frame-boundary flag for the tap-update logic. Sits between the ADC/sample source and the LMS filter core.

---
 rtl/sample_widen.sv | 107 ++++++++++
 tb/tb_sample_widen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_widen.sv
// sample_widen: widens signed samples to accumulator format through a show-ahead FIFO with frame tagging.
// Optional DC_REMOVE_EN: subtract a leaky-integrator DC estimate from each stored sample.
`default_nettype none

module sample_widen #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 32,
    parameter int SHIFT     = 8,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 32,
    parameter int DC_K      = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [IN_W-1:0]          s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [OUT_W-1:0]         m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [AW:0]   c_full     = (AW+1)'(DEPTH);
    localparam logic [FW-1:0] c_last_idx = FW'(FRAME_LEN - 1);

    logic [OUT_W:0]          r_mem [DEPTH];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_fill;
    logic [FW-1:0]           r_fidx;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_last_in;
    logic signed [OUT_W-1:0] w_widened;
    logic [OUT_W-1:0]        w_store;

    assign s_ready   = en & ~rst & (r_fill != c_full);
    assign m_valid   = (r_fill != '0);
    assign w_push    = s_valid & s_ready;
    assign w_pop     = m_valid & m_ready;
    assign w_last_in = (r_fidx == c_last_idx);

    assign w_widened = OUT_W'(signed'(s_data)) << SHIFT;

`ifdef DC_REMOVE_EN
    logic signed [OUT_W+DC_K-1:0] r_dc_acc;
    logic signed [OUT_W+DC_K-1:0] w_est;
    logic signed [OUT_W+DC_K-1:0] w_diff;

    // The estimate is taken from the accumulator before this sample's update.
    assign w_est   = r_dc_acc >>> DC_K;
    assign w_diff  = (OUT_W+DC_K)'(w_widened) - w_est;
    assign w_store = w_diff[OUT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dc_acc <= '0;
        end else if (w_push) begin
            r_dc_acc <= r_dc_acc + w_diff;
        end
    end
`else
    assign w_store = w_widened;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last_in, w_store};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_fidx   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_fidx   <= w_last_in ? '0 : r_fidx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Stale memory contents are masked so the outputs read zero while empty.
    assign m_data = m_valid ? r_mem[r_rd_ptr][OUT_W-1:0] : '0;
    assign m_last = m_valid & r_mem[r_rd_ptr][OUT_W];
    assign fill   = r_fill;

endmodule

`default_nettype wire

// File: tb/tb_sample_widen.sv
// tb_sample_widen: table vectors plus scoreboard checking of sample_widen (DEPTH=4, FRAME_LEN=4, DC_K=2).
`default_nettype none

module tb_sample_widen;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [2:0]  fill;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] din;
        logic [31:0] dout;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } exp_t;

    vec_t   tbl[$];
    exp_t   sb_q[$];
    int     mdl_fidx = 0;
    longint mdl_acc  = 0;

    sample_widen #(
        .IN_W(16), .OUT_W(32), .SHIFT(8), .DEPTH(4), .FRAME_LEN(4), .DC_K(2)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .fill(fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        while (fill != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_fill", 64'(fill), 64'd0);
    endtask

    function automatic logic [31:0] widen(input logic [15:0] d);
        return {{8{d[15]}}, d, 8'h00};
    endfunction

    function automatic logic [31:0] model_store(input logic [15:0] d);
`ifdef DC_REMOVE_EN
        longint w;
        longint est;
        longint o;
        w       = longint'($signed(widen(d)));
        est     = mdl_acc >>> 2;
        o       = w - est;
        mdl_acc = mdl_acc + o;
        return o[31:0];
`else
        return widen(d);
`endif
    endfunction

    // Handshakes are evaluated mid-cycle; they take effect at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            mdl_fidx = 0;
            mdl_acc  = 0;
        end else begin
            if (m_valid && m_ready) begin
                if (sb_q.size() == 0) begin
                    chk("pop_unexpected", 64'(m_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", 64'(m_data), 64'(e.d));
                    chk("sb_last", 64'(m_last), 64'(e.l));
                end
            end
            if (s_valid && s_ready) begin
                exp_t e;
                e.d = model_store(s_data);
                e.l = (mdl_fidx == 3);
                mdl_fidx = (mdl_fidx == 3) ? 0 : mdl_fidx + 1;
                sb_q.push_back(e);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b0;

`ifdef DC_REMOVE_EN
        tbl.push_back('{16'h0100, 32'h0001_0000});
        tbl.push_back('{16'h0100, 32'h0000_C000});
        tbl.push_back('{16'h0100, 32'h0000_9000});
`else
        tbl.push_back('{16'h7FFF, 32'h007F_FF00});
        tbl.push_back('{16'h8000, 32'hFF80_0000});
        tbl.push_back('{16'hFFFF, 32'hFFFF_FF00});
        tbl.push_back('{16'h0001, 32'h0000_0100});
`endif

        // Reset state
        tick();
        tick();
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_fill", 64'(fill), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Widening vectors, one-cycle latency
        m_ready = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            s_data  = tbl[i].din;
            s_valid = 1'b1;
            chk("wid_pre_valid", 64'(m_valid), 64'd0);
            tick();
            s_valid = 1'b0;
            chk("wid_valid", 64'(m_valid), 64'd1);
            chk("wid_data", 64'(m_data), 64'(tbl[i].dout));
            chk("wid_fill", 64'(fill), 64'd1);
            tick();
        end

        // Reset mid-stream with three queued entries
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 16'h0200 + 16'(i);
            tick();
        end
        s_valid = 1'b0;
        chk("mid_fill3", 64'(fill), 64'd3);
        rst     = 1'b1;
        s_valid = 1'b1;
        #1;
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        chk("mid_m_valid", 64'(m_valid), 64'd0);
        chk("mid_fill0", 64'(fill), 64'd0);
        chk("mid_m_last", 64'(m_last), 64'd0);

        // Frame flag with an enable gap after sample 2
        m_ready = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                en      = 1'b0;
                s_valid = 1'b1;
                s_data  = 16'd3;
                #1;
                chk("en_low_s_ready", 64'(s_ready), 64'd0);
                repeat (3) tick();
                en = 1'b1;
            end
            s_valid = 1'b1;
            s_data  = 16'(k);
            tick();
            chk("frame_valid", 64'(m_valid), 64'd1);
            chk("frame_last", 64'(m_last), 64'((k == 4) || (k == 8)));
        end
        s_valid = 1'b0;
        tick();
        chk("frame_empty", 64'(fill), 64'd0);

        // Stall stability
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        tick();
        s_data  = 16'h4321;
        tick();
        s_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_data", 64'(m_data), 64'(sb_q[0].d));
            chk("stall_last", 64'(m_last), 64'(sb_q[0].l));
        end

        // Continuous push and pop at fill=2
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_data = 16'(i * 16'h0111);
            tick();
            chk("pushpop_fill", 64'(fill), 64'd2);
        end
        s_valid = 1'b0;
        drain();

        // Backpressure: fifth sample waits until a slot frees
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_data = 16'h1000 + 16'(k);
            tick();
        end
        chk("bp_fill4", 64'(fill), 64'd4);
        chk("bp_s_ready", 64'(s_ready), 64'd0);
        s_data = 16'h1004;
        tick();
        tick();
        chk("bp_hold_fill", 64'(fill), 64'd4);
        chk("bp_hold_ready", 64'(s_ready), 64'd0);
        m_ready = 1'b1;
        tick();
        chk("bp_pop_fill", 64'(fill), 64'd3);
        chk("bp_pop_ready", 64'(s_ready), 64'd1);
        tick();
        chk("bp_accept_fill", 64'(fill), 64'd3);
        s_valid = 1'b0;
        drain();
        tick();

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
